pcie_tx_arb: RTL and testbench

- Round-robin arbiter and datapath mux that shares the single PCIe core TX transaction interface between NUM_REQ transmit engines: write/interrupt engine, read-request engine and completion engine.
- Speaks the engines' existing req_v / req_grant / req_stall / req_done handshake.
- Gates new grants on link-up and TX buffer availability.
- Drives the core's trn_t* bus from the granted engine.

---
 rtl/pcie_tx_arb.sv | 146 ++++++++++++++
 tb/tb_pcie_tx_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_arb.sv
// Round-robin arbiter and TRN mux sharing one PCIe core TX interface between NUM_REQ engines.
// Optional grant watchdog: define PCIE_TX_ARB_WATCHDOG_EN.
module pcie_tx_arb #(
    parameter int NUM_REQ     = 3,
    parameter int REQ_BITS    = 2,
    parameter int MIN_BUF_AV  = 2,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                    pcie_clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_v,
    input  logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic                    req_stall,
    input  logic [NUM_REQ*64-1:0]   req_td,
    input  logic [NUM_REQ*8-1:0]    req_trem_n,
    input  logic [NUM_REQ-1:0]      req_tsof_n,
    input  logic [NUM_REQ-1:0]      req_teof_n,
    input  logic [NUM_REQ-1:0]      req_tsrc_rdy_n,
    output logic [63:0]             trn_td,
    output logic [7:0]              trn_trem_n,
    output logic                    trn_tsof_n,
    output logic                    trn_teof_n,
    output logic                    trn_tsrc_rdy_n,
    input  logic                    trn_tdst_rdy_n,
    input  logic [5:0]              trn_tbuf_av,
    input  logic                    trn_lnk_up_n,
    output logic [REQ_BITS-1:0]     owner,
    output logic                    wdog_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [REQ_BITS-1:0]   r_owner;
    logic [REQ_BITS-1:0]   w_nextOwner;
    logic [REQ_BITS-1:0]   w_winner;
    logic                  w_found;
    logic                  w_grantOk;
    logic                  w_doneExit;
    logic                  w_wdogHit;

    if (((2 ** REQ_BITS) < NUM_REQ) || (WDOG_CYCLES < 1)) begin : g_badParam
        $error("pcie_tx_arb: REQ_BITS too narrow for NUM_REQ or WDOG_CYCLES < 1");
    end

    assign w_grantOk  = (|req_v) && !trn_lnk_up_n && (trn_tbuf_av >= 6'(MIN_BUF_AV));
    assign w_doneExit = req_done[r_owner] && !trn_tdst_rdy_n;

    // Search begins just past the last owner so it always rotates to the back.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_owner;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req_v[(int'(r_owner) + k) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = REQ_BITS'((int'(r_owner) + k) % NUM_REQ);
            end
        end
    end

`ifdef PCIE_TX_ARB_WATCHDOG_EN
    logic [15:0] r_wdogCnt;
    logic        r_wdogErr;

    assign w_wdogHit = (r_state == BUSY) && !trn_tdst_rdy_n &&
                       (r_wdogCnt >= 16'(WDOG_CYCLES - 1));

    // Counter is held clear in IDLE so every grant starts from zero.
    always_ff @(posedge pcie_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdogCnt <= '0;
            r_wdogErr <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_wdogCnt <= '0;
            end else if (!trn_tdst_rdy_n && (r_wdogCnt != 16'hffff)) begin
                r_wdogCnt <= r_wdogCnt + 16'd1;
            end
            if (w_wdogHit) begin
                r_wdogErr <= 1'b1;
            end
        end
    end

    assign wdog_err = r_wdogErr;
`else
    assign w_wdogHit = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    always_ff @(posedge pcie_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= REQ_BITS'(NUM_REQ - 1);
        end else begin
            r_state <= w_nextState;
            r_owner <= w_nextOwner;
        end
    end

    // Once granted, only done (or the watchdog) releases the bus; owner is kept for rotation.
    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        case (r_state)
            IDLE: begin
                if (w_grantOk && w_found) begin
                    w_nextState = BUSY;
                    w_nextOwner = w_winner;
                end
            end
            BUSY: begin
                if (w_doneExit || w_wdogHit) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        req_grant      = '0;
        trn_td         = '0;
        trn_trem_n     = 8'hff;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        if (r_state == BUSY) begin
            req_grant      = NUM_REQ'(1) << r_owner;
            trn_td         = req_td[int'(r_owner) * 64 +: 64];
            trn_trem_n     = req_trem_n[int'(r_owner) * 8 +: 8];
            trn_tsof_n     = req_tsof_n[r_owner];
            trn_teof_n     = req_teof_n[r_owner];
            trn_tsrc_rdy_n = req_tsrc_rdy_n[r_owner];
        end
    end

    assign req_stall = trn_tdst_rdy_n;
    assign owner     = r_owner;

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Table-driven bench for pcie_tx_arb, plus hand sequences for mid-packet reset and
// (when PCIE_TX_ARB_WATCHDOG_EN is defined) the grant watchdog.
module tb_pcie_tx_arb;

    logic          pcieClk = 1'b0;
    logic          rstN;
    logic [2:0]    reqV;
    logic [2:0]    reqDone;
    logic [2:0]    reqGrant;
    logic          reqStall;
    logic [191:0]  reqTd;
    logic [23:0]   reqTremN;
    logic [2:0]    reqTsofN;
    logic [2:0]    reqTeofN;
    logic [2:0]    reqTsrcRdyN;
    logic [63:0]   trnTd;
    logic [7:0]    trnTremN;
    logic          trnTsofN;
    logic          trnTeofN;
    logic          trnTsrcRdyN;
    logic          trnTdstRdyN;
    logic [5:0]    trnTbufAv;
    logic          trnLnkUpN;
    logic [1:0]    owner;
    logic          wdogErr;

    logic [63:0]   engTd   [3];
    logic [7:0]    engTrem [3];

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic [2:0] reqV;
        logic [2:0] reqDone;
        logic       tdstRdyN;
        logic [5:0] bufAv;
        logic       lnkUpN;
        logic [2:0] expGrant;
        logic [1:0] expOwner;
    } vec_t;

    vec_t vecs[$];

    always #5 pcieClk = ~pcieClk;

    pcie_tx_arb #(
        .NUM_REQ(3), .REQ_BITS(2), .MIN_BUF_AV(2), .WDOG_CYCLES(16)
    ) dut (
        .pcie_clk(pcieClk), .rst_n(rstN),
        .req_v(reqV), .req_done(reqDone), .req_grant(reqGrant), .req_stall(reqStall),
        .req_td(reqTd), .req_trem_n(reqTremN), .req_tsof_n(reqTsofN),
        .req_teof_n(reqTeofN), .req_tsrc_rdy_n(reqTsrcRdyN),
        .trn_td(trnTd), .trn_trem_n(trnTremN), .trn_tsof_n(trnTsofN),
        .trn_teof_n(trnTeofN), .trn_tsrc_rdy_n(trnTsrcRdyN),
        .trn_tdst_rdy_n(trnTdstRdyN), .trn_tbuf_av(trnTbufAv), .trn_lnk_up_n(trnLnkUpN),
        .owner(owner), .wdog_err(wdogErr)
    );

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [2:0] v, input logic [2:0] d, input logic tdst,
                          input logic [5:0] buf_, input logic lnk,
                          input logic [2:0] eg, input logic [1:0] eo);
        vec_t t;
        t.reqV = v; t.reqDone = d; t.tdstRdyN = tdst; t.bufAv = buf_; t.lnkUpN = lnk;
        t.expGrant = eg; t.expOwner = eo;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t v);
        reqV        = v.reqV;
        reqDone     = v.reqDone;
        trnTdstRdyN = v.tdstRdyN;
        trnTbufAv   = v.bufAv;
        trnLnkUpN   = v.lnkUpN;
    endtask

    // The trn bus must show the granted engine's slice, or idle values with no grant.
    task automatic checkOutput(input vec_t v, input int idx);
        int sel;
        logic [63:0] eTd;
        logic [7:0]  eTrem;
        logic        eSof, eEof, eSrc;
        sel = -1;
        case (v.expGrant)
            3'b001:  sel = 0;
            3'b010:  sel = 1;
            3'b100:  sel = 2;
            default: sel = -1;
        endcase
        eTd = 64'h0; eTrem = 8'hff; eSof = 1'b1; eEof = 1'b1; eSrc = 1'b1;
        if (sel >= 0) begin
            eTd = engTd[sel]; eTrem = engTrem[sel];
            eSof = reqTsofN[sel]; eEof = reqTeofN[sel]; eSrc = reqTsrcRdyN[sel];
        end
        checkVal($sformatf("v%0d grant", idx), 64'(reqGrant), 64'(v.expGrant));
        checkVal($sformatf("v%0d owner", idx), 64'(owner), 64'(v.expOwner));
        checkVal($sformatf("v%0d stall", idx), 64'(reqStall), 64'(v.tdstRdyN));
        checkVal($sformatf("v%0d td", idx), trnTd, eTd);
        checkVal($sformatf("v%0d trem", idx), 64'(trnTremN), 64'(eTrem));
        checkVal($sformatf("v%0d sof", idx), 64'(trnTsofN), 64'(eSof));
        checkVal($sformatf("v%0d eof", idx), 64'(trnTeofN), 64'(eEof));
        checkVal($sformatf("v%0d srcrdy", idx), 64'(trnTsrcRdyN), 64'(eSrc));
        checkVal($sformatf("v%0d wdog", idx), 64'(wdogErr), 64'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        engTd[0] = 64'h0123_4567_89ab_cdef;
        engTd[1] = 64'hfedc_ba98_7654_3210;
        engTd[2] = 64'ha5a5_5a5a_0f0f_f0f0;
        engTrem[0] = 8'h00;
        engTrem[1] = 8'h0f;
        engTrem[2] = 8'hf0;
        reqTd       = {engTd[2], engTd[1], engTd[0]};
        reqTremN    = {engTrem[2], engTrem[1], engTrem[0]};
        reqTsofN    = 3'b010;
        reqTeofN    = 3'b101;
        reqTsrcRdyN = 3'b100;

        rstN = 1'b0; reqV = '0; reqDone = '0;
        trnTdstRdyN = 1'b0; trnTbufAv = 6'd10; trnLnkUpN = 1'b0;

        // reqV, reqDone, tdstRdyN, bufAv, lnkUpN, expGrant, expOwner
        addVec(3'b111, 3'b000, 1'b0, 6'd10, 1'b0, 3'b000, 2'd2);
        addVec(3'b111, 3'b000, 1'b0, 6'd10, 1'b0, 3'b001, 2'd0);
        addVec(3'b111, 3'b001, 1'b0, 6'd10, 1'b0, 3'b001, 2'd0);
        addVec(3'b111, 3'b000, 1'b0, 6'd10, 1'b0, 3'b000, 2'd0);
        addVec(3'b111, 3'b000, 1'b0, 6'd10, 1'b0, 3'b010, 2'd1);
        addVec(3'b111, 3'b010, 1'b0, 6'd10, 1'b0, 3'b010, 2'd1);
        addVec(3'b111, 3'b000, 1'b0, 6'd10, 1'b0, 3'b000, 2'd1);
        addVec(3'b111, 3'b000, 1'b0, 6'd10, 1'b0, 3'b100, 2'd2);
        addVec(3'b111, 3'b100, 1'b0, 6'd10, 1'b0, 3'b100, 2'd2);
        addVec(3'b111, 3'b000, 1'b0, 6'd10, 1'b0, 3'b000, 2'd2);
        addVec(3'b111, 3'b001, 1'b0, 6'd10, 1'b0, 3'b001, 2'd0);
        // Stalled done on engine 1 must not release the grant.
        addVec(3'b010, 3'b000, 1'b0, 6'd10, 1'b0, 3'b000, 2'd0);
        addVec(3'b010, 3'b010, 1'b1, 6'd10, 1'b0, 3'b010, 2'd1);
        addVec(3'b010, 3'b010, 1'b1, 6'd10, 1'b0, 3'b010, 2'd1);
        addVec(3'b010, 3'b010, 1'b1, 6'd10, 1'b0, 3'b010, 2'd1);
        addVec(3'b010, 3'b010, 1'b0, 6'd10, 1'b0, 3'b010, 2'd1);
        addVec(3'b000, 3'b000, 1'b0, 6'd10, 1'b0, 3'b000, 2'd1);
        // Buffer threshold: 1 blocks, 2 grants.
        addVec(3'b001, 3'b000, 1'b0, 6'd1,  1'b0, 3'b000, 2'd1);
        addVec(3'b001, 3'b000, 1'b0, 6'd2,  1'b0, 3'b000, 2'd1);
        // Grant persists through foreign done, dropped req_v and link loss.
        addVec(3'b000, 3'b100, 1'b0, 6'd2,  1'b0, 3'b001, 2'd0);
        addVec(3'b000, 3'b010, 1'b0, 6'd0,  1'b0, 3'b001, 2'd0);
        addVec(3'b000, 3'b000, 1'b0, 6'd2,  1'b1, 3'b001, 2'd0);
        addVec(3'b111, 3'b001, 1'b0, 6'd10, 1'b1, 3'b001, 2'd0);
        addVec(3'b111, 3'b000, 1'b0, 6'd10, 1'b1, 3'b000, 2'd0);
        addVec(3'b111, 3'b000, 1'b0, 6'd10, 1'b1, 3'b000, 2'd0);
        addVec(3'b110, 3'b000, 1'b0, 6'd10, 1'b0, 3'b000, 2'd0);
        addVec(3'b000, 3'b010, 1'b0, 6'd10, 1'b0, 3'b010, 2'd1);
        addVec(3'b000, 3'b111, 1'b0, 6'd10, 1'b0, 3'b000, 2'd1);
        addVec(3'b000, 3'b000, 1'b0, 6'd10, 1'b0, 3'b000, 2'd1);

        #22;
        checkVal("reset grant", 64'(reqGrant), 64'h0);
        checkVal("reset owner", 64'(owner), 64'h2);
        checkVal("reset td", trnTd, 64'h0);
        checkVal("reset trem", 64'(trnTremN), 64'hff);
        checkVal("reset srcrdy", 64'(trnTsrcRdyN), 64'h1);
        checkVal("reset wdog", 64'(wdogErr), 64'h0);
        @(negedge pcieClk);
        rstN = 1'b1;
        @(posedge pcieClk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
            @(posedge pcieClk);
            #1;
        end

        // Mid-packet asynchronous reset: grant engine 0, then reset between edges.
        reqV = 3'b001; reqDone = '0; trnTdstRdyN = 1'b0; trnTbufAv = 6'd10; trnLnkUpN = 1'b0;
        @(posedge pcieClk);
        #1;
        checkVal("mid grant before reset", 64'(reqGrant), 64'h1);
        checkVal("mid td before reset", trnTd, engTd[0]);
        #2;
        rstN = 1'b0;
        #1;
        checkVal("mid reset grant", 64'(reqGrant), 64'h0);
        checkVal("mid reset owner", 64'(owner), 64'h2);
        checkVal("mid reset td", trnTd, 64'h0);
        checkVal("mid reset trem", 64'(trnTremN), 64'hff);
        checkVal("mid reset sof", 64'(trnTsofN), 64'h1);
        reqV = '0;
        @(negedge pcieClk);
        rstN = 1'b1;
        @(posedge pcieClk);
        #1;

`ifdef PCIE_TX_ARB_WATCHDOG_EN
        begin
            int busyCycles;
            reqV = 3'b011; reqDone = '0; trnTdstRdyN = 1'b0;
            @(posedge pcieClk);
            #1;
            checkVal("wdog first grant", 64'(reqGrant), 64'h1);
            busyCycles = 0;
            while ((reqGrant == 3'b001) && (busyCycles < 64)) begin
                busyCycles++;
                @(posedge pcieClk);
                #1;
            end
            checkVal("wdog busy cycles", 64'(busyCycles), 64'd16);
            checkVal("wdog grant dropped", 64'(reqGrant), 64'h0);
            checkVal("wdog err set", 64'(wdogErr), 64'h1);
            @(posedge pcieClk);
            #1;
            checkVal("wdog next grant", 64'(reqGrant), 64'h2);
            reqDone = 3'b010;
            @(posedge pcieClk);
            #1;
            reqDone = '0; reqV = '0;
            @(posedge pcieClk);
            #1;
            checkVal("wdog err sticky", 64'(wdogErr), 64'h1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
